// File: rtl/lcd_vram_pkg.sv
// Shared types and default widths for the LCD character-RAM arbiter.
//   owner_t : who owns the RAM op in flight (used as the response tag)
//   state_t : clear-engine FSM states
package lcd_vram_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 1020;

  typedef enum logic [1:0] {OWN_NONE, OWN_DISP, OWN_CPU, OWN_CLR} owner_t;
  typedef enum logic       {ST_IDLE, ST_CLEAR} state_t;

endpackage

// File: rtl/lcd_vram_rsp_pipe.sv
// Response pipe: a 2-stage owner tag follows each RAM op, and the read data
// is steered to the display or CPU output registers when the tag reaches the
// end of the pipe.
// Ports:
//   PixelClk, nRST          clock / async active-low reset
//   tag_in                  owner of the op granted this cycle (owner_t)
//   ram_rdata               RAM read data (valid two cycles after grant)
//   disp_valid, disp_data   display response (1-cycle pulse + data)
//   cpu_rvalid, cpu_rdata   CPU read response (1-cycle pulse + data)
module lcd_vram_rsp_pipe
  import lcd_vram_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              PixelClk,
  input  logic              nRST,
  input  logic [1:0]        tag_in,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_data,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata
);

  // [0]: op on the RAM strobes, [1]: ram_rdata valid for this op
  owner_t tag_pipe [2];

  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      tag_pipe[0] <= OWN_NONE;
      tag_pipe[1] <= OWN_NONE;
      disp_valid  <= 1'b0;
      disp_data   <= '0;
      cpu_rvalid  <= 1'b0;
      cpu_rdata   <= '0;
    end else begin
      tag_pipe[0] <= owner_t'(tag_in);
      tag_pipe[1] <= tag_pipe[0];
      disp_valid  <= (tag_pipe[1] == OWN_DISP);
      cpu_rvalid  <= (tag_pipe[1] == OWN_CPU);
      if (tag_pipe[1] == OWN_DISP) disp_data <= ram_rdata;
      if (tag_pipe[1] == OWN_CPU)  cpu_rdata <= ram_rdata;
    end
  end

endmodule

// File: rtl/lcd_vram_arbiter.sv
// Single-port text BSRAM arbiter: LCD renderer > clear engine > CPU.
// One RAM op per cycle; display fetch latency is a fixed 3 cycles.
// Ports:
//   PixelClk, nRST                     clock / async active-low reset
//   disp_req/disp_addr                 renderer fetch (no backpressure)
//   disp_valid/disp_data               renderer response, request + 3 cycles
//   cpu_req/cpu_we/cpu_addr/cpu_wdata  CPU request, held until cpu_ready
//   cpu_ready                          combinational accept
//   cpu_rvalid/cpu_rdata               CPU read response, accept + 3 cycles
//   clr_start/clr_busy/clr_done        clear-screen sweep control/status
//   ram_ce/ram_we/ram_addr/ram_wdata   registered RAM strobes
//   ram_rdata                          RAM read data, 1 cycle after ram_ce
module lcd_vram_arbiter
  import lcd_vram_pkg::*;
#(
  parameter int                ADDR_W    = ADDR_W_DEF,
  parameter int                DATA_W    = DATA_W_DEF,
  parameter int                DEPTH     = DEPTH_DEF,
  parameter logic [DATA_W-1:0] FILL_CHAR = '0
) (
  input  logic              PixelClk,
  input  logic              nRST,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_data,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              ram_ce,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic              gnt_disp, gnt_clr, gnt_cpu;
  owner_t            tag_in;

  assign clr_busy = (state == ST_CLEAR);

  // Fixed priority; the CPU is locked out for the whole sweep. nRST gates the
  // accept so nothing is handshaken while the block is held in reset.
  assign gnt_disp  = disp_req;
  assign gnt_clr   = ~disp_req & clr_busy;
  assign cpu_ready = cpu_req & ~disp_req & ~clr_busy & nRST;
  assign gnt_cpu   = cpu_ready;

  // CPU writes and clear writes need no response routing.
  always_comb begin
    tag_in = OWN_NONE;
    if (gnt_disp)                tag_in = OWN_DISP;
    else if (gnt_clr)            tag_in = OWN_CLR;
    else if (gnt_cpu && !cpu_we) tag_in = OWN_CPU;
  end

  // Registered RAM strobes; address/data hold on idle cycles.
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      ram_ce    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      ram_ce <= gnt_disp | gnt_clr | gnt_cpu;
      ram_we <= gnt_clr | (gnt_cpu & cpu_we);
      if (gnt_disp) begin
        ram_addr <= disp_addr;
      end else if (gnt_clr) begin
        ram_addr  <= cnt;
        ram_wdata <= FILL_CHAR;
      end else if (gnt_cpu) begin
        ram_addr  <= cpu_addr;
        ram_wdata <= cpu_wdata;
      end
    end
  end

  // Clear engine: advances only on slots the display leaves free.
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      clr_done <= 1'b0;
    end else begin
      clr_done <= 1'b0;
      case (state)
        ST_IDLE: if (clr_start) state <= ST_CLEAR;
        ST_CLEAR: begin
          if (gnt_clr) begin
            if (cnt == LAST) begin
              cnt      <= '0;
              state    <= ST_IDLE;
              clr_done <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  lcd_vram_rsp_pipe #(.DATA_W(DATA_W)) u_rsp (
    .PixelClk   (PixelClk),
    .nRST       (nRST),
    .tag_in     (tag_in),
    .ram_rdata  (ram_rdata),
    .disp_valid (disp_valid),
    .disp_data  (disp_data),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata)
  );

endmodule

// File: tb/tb_lcd_vram_arbiter.sv
// Bench for lcd_vram_arbiter: behavioural RAM, a cycle-level reference model
// (priority rules, 3-cycle response schedule, shadow memory), a directed
// vector table, clear/abort sequences and a randomized run.
module tb_lcd_vram_arbiter;
  import lcd_vram_pkg::*;

  localparam int         AW   = 10;
  localparam int         DW   = 8;
  localparam int         DEP  = 16;
  localparam logic [7:0] FILL = 8'h20;

  logic          PixelClk = 1'b0;
  logic          nRST = 1'b0;
  logic          disp_req = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0, clr_start = 1'b0;
  logic [AW-1:0] disp_addr = '0, cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          disp_valid, cpu_ready, cpu_rvalid, clr_busy, clr_done, ram_ce, ram_we;
  logic [DW-1:0] disp_data, cpu_rdata, ram_wdata, ram_rdata;
  logic [AW-1:0] ram_addr;

  always #5 PixelClk = ~PixelClk;

  lcd_vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP), .FILL_CHAR(FILL)) dut (
    .PixelClk(PixelClk), .nRST(nRST),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_valid(disp_valid), .disp_data(disp_data),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  function automatic logic [7:0] init_val(input int i);
    if (i == 5) return 8'd7;
    if (i == 3) return 8'h33;
    if (i == 9) return 8'h5A;
    return 8'(i * 37 + 11);
  endfunction

  // Synchronous single-port RAM, one process owns the array.
  logic [7:0] ram_mem [1024];
  initial begin
    ram_rdata = '0;
    for (int i = 0; i < 1024; i++) ram_mem[i] = init_val(i);
    forever begin
      @(posedge PixelClk);
      if (ram_ce) begin
        if (ram_we) ram_mem[ram_addr] <= ram_wdata;
        else        ram_rdata <= ram_mem[ram_addr];
      end
    end
  end

  typedef struct packed {
    logic       ready, ce, we, busy, done, dv, cv;
    logic [9:0] addr;
    logic [7:0] wdata, ddata, cdata;
  } obs_t;
  obs_t obs;

  int total = 0, bad = 0, cyc = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] shadow [1024];
  logic       m_clearing;
  int         m_cnt;
  logic       e_ce, e_we, e_done;
  logic [9:0] e_addr;
  logic [7:0] e_wdata;
  logic       p_wr;             // write on the RAM bus next cycle
  logic [9:0] p_addr;
  logic [7:0] p_data;
  logic       r_dv [4], r_cv [4];
  logic [7:0] r_d [4];

  task automatic model_reset();
    m_clearing = 0; m_cnt = 0;
    e_ce = 0; e_we = 0; e_done = 0; e_addr = '0; e_wdata = '0;
    p_wr = 0;
    for (int i = 0; i < 4; i++) begin r_dv[i] = 0; r_cv[i] = 0; r_d[i] = '0; end
  endtask

  // One cycle: sample at negedge, compare, advance model, return at posedge+1.
  task automatic tick();
    logic e_ready;
    int   s, s3;
    @(negedge PixelClk);
    obs.ready = cpu_ready; obs.ce = ram_ce; obs.we = ram_we; obs.busy = clr_busy;
    obs.done = clr_done; obs.dv = disp_valid; obs.cv = cpu_rvalid; obs.addr = ram_addr;
    obs.wdata = ram_wdata; obs.ddata = disp_data; obs.cdata = cpu_rdata;
    if (!nRST) begin
      chk("reset_outputs", 64'(obs), 64'd0);
      model_reset();
    end else begin
      s  = cyc % 4;
      s3 = (cyc + 3) % 4;
      e_ready = cpu_req && !disp_req && !m_clearing;
      chk("cpu_ready", obs.ready, e_ready);
      chk("ram_ce", obs.ce, e_ce);
      chk("ram_we", obs.we, e_we);
      chk("ram_addr", obs.addr, e_addr);
      if (e_we) chk("ram_wdata", obs.wdata, e_wdata);
      chk("clr_busy", obs.busy, m_clearing);
      chk("clr_done", obs.done, e_done);
      chk("disp_valid", obs.dv, r_dv[s]);
      if (r_dv[s]) chk("disp_data", obs.ddata, r_d[s]);
      chk("cpu_rvalid", obs.cv, r_cv[s]);
      if (r_cv[s]) chk("cpu_rdata", obs.cdata, r_d[s]);
      r_dv[s] = 0; r_cv[s] = 0;
      if (p_wr) shadow[p_addr] = p_data;
      p_wr = 0;
      e_ce = 0; e_we = 0; e_done = 0;
      if (disp_req) begin
        e_ce = 1; e_addr = disp_addr;
        r_dv[s3] = 1; r_d[s3] = shadow[disp_addr];
      end else if (m_clearing) begin
        e_ce = 1; e_we = 1; e_addr = 10'(m_cnt); e_wdata = FILL;
        p_wr = 1; p_addr = 10'(m_cnt); p_data = FILL;
        if (m_cnt == DEP - 1) begin m_cnt = 0; m_clearing = 0; e_done = 1; end
        else m_cnt++;
      end else if (cpu_req) begin
        e_ce = 1; e_we = cpu_we; e_addr = cpu_addr;
        if (cpu_we) begin
          e_wdata = cpu_wdata; p_wr = 1; p_addr = cpu_addr; p_data = cpu_wdata;
        end else begin
          r_cv[s3] = 1; r_d[s3] = shadow[cpu_addr];
        end
      end
      if (!e_done && !m_clearing && clr_start && !obs.busy) m_clearing = 1;
    end
    cyc++;
    @(posedge PixelClk);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       dreq; logic [9:0] daddr;
    logic       creq, cwe; logic [9:0] caddr; logic [7:0] cwd;
    logic       x_ready, x_ce, x_we; logic [9:0] x_addr;
    logic       x_dv; logic [7:0] x_dd;
    logic       x_cv; logic [7:0] x_cd;
  } vec_t;
  vec_t tbl [16];

  int   nwr, ndone, stall_bad;
  logic acc, seen;

  initial begin
    for (int i = 0; i < 1024; i++) shadow[i] = init_val(i);
    model_reset();

    // reset held with random inputs
    for (int k = 0; k < 5; k++) begin
      disp_req = 1'($urandom); cpu_req = 1'($urandom); cpu_we = 1'($urandom);
      clr_start = 1'($urandom); disp_addr = 10'($urandom); cpu_addr = 10'($urandom);
      cpu_wdata = 8'($urandom);
      tick();
    end
    nRST = 1; disp_req = 0; cpu_req = 0; cpu_we = 0; clr_start = 0;

    //           dreq daddr creq cwe caddr cwd  rdy ce we addr dv dd     cv cd
    tbl[0]  = '{1, 10'd5, 0, 0, 10'd0,  8'd0, 0, 0, 0, 10'd0,  0, 8'd0,  0, 8'd0};
    tbl[1]  = '{0, 10'd0, 0, 0, 10'd0,  8'd0, 0, 1, 0, 10'd5,  0, 8'd0,  0, 8'd0};
    tbl[2]  = '{0, 10'd0, 0, 0, 10'd0,  8'd0, 0, 0, 0, 10'd0,  0, 8'd0,  0, 8'd0};
    tbl[3]  = '{0, 10'd0, 0, 0, 10'd0,  8'd0, 0, 0, 0, 10'd0,  1, 8'd7,  0, 8'd0};
    tbl[4]  = '{1, 10'd3, 1, 0, 10'd9,  8'd0, 0, 0, 0, 10'd0,  0, 8'd0,  0, 8'd0};
    tbl[5]  = '{0, 10'd0, 1, 0, 10'd9,  8'd0, 1, 1, 0, 10'd3,  0, 8'd0,  0, 8'd0};
    tbl[6]  = '{0, 10'd0, 0, 0, 10'd0,  8'd0, 0, 1, 0, 10'd9,  0, 8'd0,  0, 8'd0};
    tbl[7]  = '{0, 10'd0, 0, 0, 10'd0,  8'd0, 0, 0, 0, 10'd0,  1, 8'h33, 0, 8'd0};
    tbl[8]  = '{0, 10'd0, 0, 0, 10'd0,  8'd0, 0, 0, 0, 10'd0,  0, 8'd0,  1, 8'h5A};
    tbl[9]  = '{0, 10'd0, 1, 1, 10'd12, 8'd4, 1, 0, 0, 10'd0,  0, 8'd0,  0, 8'd0};
    tbl[10] = '{0, 10'd0, 0, 0, 10'd0,  8'd0, 0, 1, 1, 10'd12, 0, 8'd0,  0, 8'd0};
    tbl[11] = '{0, 10'd0, 1, 0, 10'd12, 8'd0, 1, 0, 0, 10'd0,  0, 8'd0,  0, 8'd0};
    tbl[12] = '{0, 10'd0, 0, 0, 10'd0,  8'd0, 0, 1, 0, 10'd12, 0, 8'd0,  0, 8'd0};
    tbl[13] = '{0, 10'd0, 0, 0, 10'd0,  8'd0, 0, 0, 0, 10'd0,  0, 8'd0,  0, 8'd0};
    tbl[14] = '{0, 10'd0, 0, 0, 10'd0,  8'd0, 0, 0, 0, 10'd0,  0, 8'd0,  1, 8'd4};
    tbl[15] = '{0, 10'd0, 0, 0, 10'd0,  8'd0, 0, 0, 0, 10'd0,  0, 8'd0,  0, 8'd0};

    for (int i = 0; i < 16; i++) begin
      disp_req = tbl[i].dreq; disp_addr = tbl[i].daddr;
      cpu_req = tbl[i].creq; cpu_we = tbl[i].cwe; cpu_addr = tbl[i].caddr; cpu_wdata = tbl[i].cwd;
      tick();
      chk($sformatf("tbl%0d_strobes", i), {obs.ready, obs.ce, obs.we, obs.dv, obs.cv},
          {tbl[i].x_ready, tbl[i].x_ce, tbl[i].x_we, tbl[i].x_dv, tbl[i].x_cv});
      if (tbl[i].x_ce) chk($sformatf("tbl%0d_addr", i), obs.addr, tbl[i].x_addr);
      if (tbl[i].x_dv) chk($sformatf("tbl%0d_ddata", i), obs.ddata, tbl[i].x_dd);
      if (tbl[i].x_cv) chk($sformatf("tbl%0d_cdata", i), obs.cdata, tbl[i].x_cd);
    end
    cpu_req = 0; cpu_we = 0; disp_req = 0;

    // clear sweep: starts together with a display fetch, CPU read held
    disp_req = 1; disp_addr = 10'd7; clr_start = 1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 10'd2;
    tick();
    chk("clr_start_cpu_ready", obs.ready, 1'b0);
    disp_req = 0; clr_start = 0;
    nwr = 0; ndone = 0; stall_bad = 0; acc = 0;
    for (int k = 0; k < 100 && !acc; k++) begin
      disp_req = (k % 8 == 7); disp_addr = 10'(k + 100); clr_start = (k == 3);
      tick();
      if (obs.ce && obs.we) begin
        chk("clr_wr_addr", obs.addr, 10'(nwr));
        chk("clr_wr_data", obs.wdata, FILL);
        nwr++;
      end
      if (obs.done) ndone++;
      if (obs.ready && obs.busy) stall_bad++;
      if (obs.ready) acc = 1;
    end
    cpu_req = 0; disp_req = 0; clr_start = 0;
    chk("clr_write_count", nwr, DEP);
    chk("clr_done_count", ndone, 1);
    chk("clr_cpu_stall", stall_bad, 0);
    chk("clr_cpu_accepted", acc, 1'b1);
    repeat (5) tick();

    // abort: reset while the sweep is at cnt=6
    clr_start = 1; tick(); clr_start = 0;
    seen = 0;
    for (int k = 0; k < 60 && !seen; k++) begin
      tick();
      if (obs.ce && obs.we && obs.addr == 10'd5) seen = 1;
    end
    chk("abort_reached_cnt", seen, 1'b1);
    nRST = 0; ndone = 0;
    repeat (3) begin tick(); ndone += int'(obs.done); end
    nRST = 1; cpu_req = 1; cpu_we = 0; cpu_addr = 10'd6;
    tick();
    chk("abort_busy", obs.busy, 1'b0);
    chk("abort_cpu_ready", obs.ready, 1'b1);
    ndone += int'(obs.done);
    cpu_req = 0;
    repeat (6) begin tick(); ndone += int'(obs.done); end
    chk("abort_no_done", ndone, 0);

    // randomized traffic against the model
    for (int k = 0; k < 1500; k++) begin
      disp_req = ($urandom_range(0, 3) == 0);
      disp_addr = 10'($urandom_range(0, 1023));
      clr_start = ($urandom_range(0, 199) == 0);
      if (!cpu_req && $urandom_range(0, 2) == 0) begin
        cpu_req = 1; cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = 10'($urandom_range(0, 31)); cpu_wdata = 8'($urandom);
      end
      tick();
      if (obs.ready) cpu_req = 0;
    end
    disp_req = 0; clr_start = 0; cpu_req = 0;
    repeat (40) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
